// File: rtl/chad_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : chad_irq_ctrl
// Brief    : Interrupt scheduler for the chad core. Edge-latches up to 15
//            sources, masks them, selects the lowest-index pending source and
//            holds irq/ivec until the core acknowledges.
// Revision : 1.0 - initial release
// ============================================================================
module chad_irq_ctrl #(
  parameter int WIDTH = 18,
  parameter int NSRC  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hold,
  input  logic             io_sel,
  input  logic [1:0]       io_addr,
  input  logic             io_wr,
  input  logic             io_rd,
  input  logic [WIDTH-1:0] io_wdata,
  output logic [WIDTH-1:0] io_rdata,
  input  logic [NSRC-1:0]  src,
  output logic             irq,
  output logic [3:0]       ivec,
  input  logic             iack
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_REQ  = 1'b1;

  localparam logic [1:0] A_PEND = 2'd0;
  localparam logic [1:0] A_EN   = 2'd1;
  localparam logic [1:0] A_CTRL = 2'd2;
  localparam logic [1:0] A_LAST = 2'd3;

  logic [NSRC-1:0] src_q;
  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] en_q,   en_d;
  logic            gie_q,  gie_d;
  logic [3:0]      last_q, last_d;
  logic [0:0]      state_q, state_d;
  logic [3:0]      sel_q,  sel_d;

  logic            w_wr;
  logic [NSRC-1:0] w_edge;
  logic [NSRC-1:0] w_cand;
  logic            w_req;
  logic [3:0]      w_enc;
  logic [NSRC-1:0] w_sel_mask;
  logic            w_sel_live;
  logic            w_ack;
  logic            w_unused;

  assign w_wr     = io_sel & io_wr & ~hold;
  assign w_edge   = src & ~src_q;
  assign w_cand   = pend_q & en_q;
  assign w_req    = gie_q & (|w_cand);
  assign w_ack    = (state_q == S_REQ) & iack;
  // Read strobe has no side effects and upper write bits have no storage.
  assign w_unused = ^{io_rd, io_wdata};

  // Priority encoder: the lowest-index candidate wins.
  always_comb begin
    w_enc = 4'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (w_cand[i]) w_enc = 4'(i);
    end
  end

  // One-hot decode of the frozen selection, used for ack-clear and retract.
  always_comb begin
    w_sel_mask = '0;
    for (int i = 0; i < NSRC; i++) begin
      w_sel_mask[i] = (sel_q == 4'(i));
    end
  end

  assign w_sel_live = gie_q & (|(w_sel_mask & pend_q & en_q));

  // Register file next-state; a new edge beats both W1C and ack clear.
  always_comb begin
    pend_d = pend_q;
    en_d   = en_q;
    gie_d  = gie_q;
    last_d = last_q;
    if (w_wr && io_addr == A_PEND) pend_d = pend_d & ~io_wdata[NSRC-1:0];
    if (w_wr && io_addr == A_EN)   en_d   = io_wdata[NSRC-1:0];
    if (w_wr && io_addr == A_CTRL) gie_d  = io_wdata[0];
    if (w_ack) begin
      pend_d = pend_d & ~w_sel_mask;
      gie_d  = 1'b0;
      last_d = sel_q + 4'd1;
    end
    pend_d = pend_d | w_edge;
  end

  // Request FSM: latch the winner on entry to REQ and hold it until retired.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    case (state_q)
      S_IDLE: begin
        if (w_req) begin
          state_d = S_REQ;
          sel_d   = w_enc;
        end
      end
      S_REQ: begin
        if (iack)             state_d = S_IDLE;
        else if (!w_sel_live) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      src_q   <= '0;
      pend_q  <= '0;
      en_q    <= '0;
      gie_q   <= 1'b0;
      last_q  <= 4'd0;
      state_q <= S_IDLE;
      sel_q   <= 4'd0;
    end else begin
      src_q   <= src;
      pend_q  <= pend_d;
      en_q    <= en_d;
      gie_q   <= gie_d;
      last_q  <= last_d;
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  assign irq  = (state_q == S_REQ);
  assign ivec = irq ? (sel_q + 4'd1) : 4'd0;

  // Combinational read mux; zero when not selected and above implemented bits.
  always_comb begin
    io_rdata = '0;
    if (io_sel) begin
      case (io_addr)
        A_PEND:  io_rdata[NSRC-1:0] = pend_q;
        A_EN:    io_rdata[NSRC-1:0] = en_q;
        A_CTRL:  io_rdata[1:0]      = {irq, gie_q};
        A_LAST:  io_rdata[3:0]      = last_q;
        default: io_rdata = '0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_chad_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_chad_irq_ctrl
// Brief    : Directed self-checking bench for chad_irq_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_chad_irq_ctrl;

  localparam int WIDTH = 18;
  localparam int NSRC  = 8;

  logic             clk;
  logic             reset;
  logic             hold;
  logic             io_sel;
  logic [1:0]       io_addr;
  logic             io_wr;
  logic             io_rd;
  logic [WIDTH-1:0] io_wdata;
  logic [WIDTH-1:0] io_rdata;
  logic [NSRC-1:0]  src;
  logic             irq;
  logic [3:0]       ivec;
  logic             iack;

  int n_chk;
  int n_pass;

  chad_irq_ctrl #(.WIDTH(WIDTH), .NSRC(NSRC)) dut (
    .clk      (clk),
    .reset    (reset),
    .hold     (hold),
    .io_sel   (io_sel),
    .io_addr  (io_addr),
    .io_wr    (io_wr),
    .io_rd    (io_rd),
    .io_wdata (io_wdata),
    .io_rdata (io_rdata),
    .src      (src),
    .irq      (irq),
    .ivec     (ivec),
    .iack     (iack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    else n_pass++;
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [WIDTH-1:0] d);
    io_sel = 1'b1; io_wr = 1'b1; io_addr = a; io_wdata = d;
    tick();
    io_sel = 1'b0; io_wr = 1'b0; io_wdata = '0;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] v;
    io_sel = 1'b1; io_rd = 1'b1; io_addr = a;
    #1;
    v = 32'(io_rdata);
    io_sel = 1'b0; io_rd = 1'b0;
    chk(tag, v, exp);
  endtask

  task automatic ack();
    iack = 1'b1;
    tick();
    iack = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    reset = 1'b0; hold = 1'b0; io_sel = 1'b0; io_addr = 2'd0; io_wr = 1'b0;
    io_rd = 1'b0; io_wdata = '0; src = '0; iack = 1'b0;
    #2;
    do_reset();

    // Reset state
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_ivec", 32'(ivec), 32'd0);
    rd_chk("rst_pend", 2'd0, 32'h0);
    rd_chk("rst_en", 2'd1, 32'h0);
    rd_chk("rst_ctrl", 2'd2, 32'h0);
    rd_chk("rst_last", 2'd3, 32'h0);

    // 1: single source, latency and ack
    wr_reg(2'd1, 18'h3FFFF);
    rd_chk("en_upper_zero", 2'd1, 32'hFF);
    io_addr = 2'd1;
    #1 chk("rdata_unsel", 32'(io_rdata), 32'h0);
    wr_reg(2'd2, 18'h1);
    src = 8'h20;
    tick();
    src = 8'h00;
    chk("t1_irq_n1", 32'(irq), 32'd0);
    rd_chk("t1_pend", 2'd0, 32'h20);
    tick();
    chk("t1_irq_n2", 32'(irq), 32'd1);
    chk("t1_ivec", 32'(ivec), 32'd6);
    rd_chk("t1_ctrl_req", 2'd2, 32'h3);
    ack();
    chk("t1_irq_ack", 32'(irq), 32'd0);
    chk("t1_ivec_ack", 32'(ivec), 32'd0);
    rd_chk("t1_pend_ack", 2'd0, 32'h0);
    rd_chk("t1_ctrl_ack", 2'd2, 32'h0);
    rd_chk("t1_last", 2'd3, 32'h6);

    // 2: simultaneous edges, priority
    src = 8'h44;
    tick();
    src = 8'h00;
    wr_reg(2'd2, 18'h1);
    tick();
    chk("t2_ivec3", 32'(ivec), 32'd3);
    ack();
    rd_chk("t2_pend", 2'd0, 32'h40);
    rd_chk("t2_last", 2'd3, 32'h3);
    wr_reg(2'd2, 18'h1);
    tick();
    chk("t2_ivec7", 32'(ivec), 32'd7);

    // 3: selection frozen while in REQ
    src = 8'h01;
    tick();
    src = 8'h00;
    tick();
    chk("t3_ivec_frozen", 32'(ivec), 32'd7);
    rd_chk("t3_pend", 2'd0, 32'h41);
    ack();
    rd_chk("t3_last", 2'd3, 32'h7);
    wr_reg(2'd2, 18'h1);
    tick();
    chk("t3_ivec1", 32'(ivec), 32'd1);
    ack();
    rd_chk("t3_pend_clr", 2'd0, 32'h0);

    // 4: software retract by W1C
    src = 8'h40;
    tick();
    src = 8'h00;
    wr_reg(2'd2, 18'h1);
    tick();
    chk("t4_ivec7", 32'(ivec), 32'd7);
    wr_reg(2'd0, 18'h40);
    tick();
    chk("t4_irq_retract", 32'(irq), 32'd0);
    chk("t4_ivec_retract", 32'(ivec), 32'd0);
    rd_chk("t4_pend", 2'd0, 32'h0);
    rd_chk("t4_ctrl", 2'd2, 32'h1);
    rd_chk("t4_last", 2'd3, 32'h1);

    // 5: edge beats W1C; ack beats GIE write
    src = 8'h08;
    wr_reg(2'd0, 18'h08);
    src = 8'h00;
    rd_chk("t5_pend_set_wins", 2'd0, 32'h08);
    tick();
    chk("t5_ivec4", 32'(ivec), 32'd4);
    iack = 1'b1;
    wr_reg(2'd2, 18'h1);
    iack = 1'b0;
    rd_chk("t5_ack_beats_gie", 2'd2, 32'h0);
    rd_chk("t5_last", 2'd3, 32'h4);

    // 6: hold blocks writes; reset mid-request
    hold = 1'b1;
    wr_reg(2'd1, 18'h0);
    wr_reg(2'd2, 18'h1);
    hold = 1'b0;
    rd_chk("t6_hold_en", 2'd1, 32'hFF);
    rd_chk("t6_hold_ctrl", 2'd2, 32'h0);
    src = 8'h02;
    tick();
    src = 8'h00;
    wr_reg(2'd2, 18'h1);
    tick();
    chk("t6_irq", 32'(irq), 32'd1);
    chk("t6_ivec2", 32'(ivec), 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_rst_irq", 32'(irq), 32'd0);
    chk("t6_rst_ivec", 32'(ivec), 32'd0);
    rd_chk("t6_rst_pend", 2'd0, 32'h0);
    rd_chk("t6_rst_en", 2'd1, 32'h0);
    rd_chk("t6_rst_ctrl", 2'd2, 32'h0);
    rd_chk("t6_rst_last", 2'd3, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
